// File: rtl/morph_pkg.sv
// Shared types and default geometry for the binary morphology frame sequencer.
package morph_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_BYPASS = 2'b00,
        OP_ERODE  = 2'b01,
        OP_DILATE = 2'b10,
        OP_RSVD   = 2'b11
    } op_t;

    localparam int DEF_H_ACT    = 640;
    localparam int DEF_V_ACT    = 480;
    localparam int DEF_CORE_LAT = 641;

    // The reserved encoding collapses to bypass so only three modes reach the datapath.
    function automatic op_t decode_op(input logic [1:0] sel);
        op_t op;
        case (sel)
            2'b01:   op = OP_ERODE;
            2'b10:   op = OP_DILATE;
            default: op = OP_BYPASS;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/morph_pos_counter.sv
// Output raster position tracker: column/row counters with start-of-frame,
// end-of-line and border flags for the position of the next output.
module morph_pos_counter
    import morph_pkg::*;
#(
    parameter int H_ACT = DEF_H_ACT,
    parameter int V_ACT = DEF_V_ACT
)(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_adv,
    output logic o_sof,
    output logic o_eol,
    output logic o_border
);

    localparam logic [9:0] COL_LAST = 10'(H_ACT - 1);
    localparam logic [8:0] ROW_LAST = 9'(V_ACT - 1);

    logic [8:0] r_row;
    logic [9:0] r_col;

    // Advance one position per emitted output, wrapping the column into the next row.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_row <= 9'd0;
            r_col <= 10'd0;
        end else if (i_clr) begin
            r_row <= 9'd0;
            r_col <= 10'd0;
        end else if (i_adv) begin
            if (r_col == COL_LAST) begin
                r_col <= 10'd0;
                r_row <= (r_row == ROW_LAST) ? 9'd0 : r_row + 9'd1;
            end else begin
                r_col <= r_col + 10'd1;
                r_row <= r_row;
            end
        end else begin
            r_row <= r_row;
            r_col <= r_col;
        end
    end

    assign o_sof    = (r_row == 9'd0) && (r_col == 10'd0);
    assign o_eol    = (r_col == COL_LAST);
    assign o_border = (r_row == 9'd0) || (r_row == ROW_LAST) ||
                      (r_col == 10'd0) || (r_col == COL_LAST);

endmodule

// File: rtl/morph_sequencer.sv
// Frame sequencer around an external 3x3 erosion core: feeds pixels, flushes the
// core pipeline, and emits a bordered erode/dilate (or bypass) result stream.
module morph_sequencer
    import morph_pkg::*;
#(
    parameter int H_ACT    = DEF_H_ACT,
    parameter int V_ACT    = DEF_V_ACT,
    parameter int CORE_LAT = DEF_CORE_LAT
)(
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [1:0] op_sel,
    input  logic       in_valid,
    input  logic       in_pixel,
    output logic       in_ready,
    output logic       core_clr,
    output logic       core_en,
    output logic       core_din,
    input  logic       core_dout,
    output logic       out_valid,
    output logic       out_pixel,
    output logic       out_sof,
    output logic       out_eol,
    output logic       busy,
    output logic       done
);

    localparam logic [18:0] FRAME_PIX = 19'(H_ACT * V_ACT);
    localparam logic [18:0] LAT       = 19'(CORE_LAT);

    state_t      r_state, w_next;
    op_t         r_op;
    logic [18:0] r_in_cnt, r_en_cnt, r_out_cnt;
    logic        w_ready, w_en, w_din, w_clr, w_xfer, w_emit, w_pix;
    logic        w_sof, w_eol, w_border;
    logic        r_out_valid, r_out_pixel, r_out_sof, r_out_eol, r_busy, r_done;

    // Next-state and core-side handshake decode.
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_en    = 1'b0;
        w_din   = 1'b0;
        w_clr   = 1'b0;
        w_xfer  = 1'b0;
        case (r_state)
            ST_IDLE:  w_next = start ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: begin
                w_clr  = 1'b1;
                w_next = ST_RUN;
            end
            ST_RUN: begin
                w_ready = 1'b1;
                w_xfer  = in_valid;
                if (r_op == OP_BYPASS) begin
                    w_en  = 1'b0;
                    w_din = 1'b0;
                end else begin
                    w_en  = in_valid;
                    w_din = (r_op == OP_DILATE) ? ~in_pixel : in_pixel;
                end
                if (in_valid && (r_in_cnt == FRAME_PIX - 19'd1)) begin
                    w_next = (r_op == OP_BYPASS) ? ST_DONE : ST_FLUSH;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_FLUSH: begin
                w_en = 1'b1;
                if ((r_en_cnt >= LAT) && (r_out_cnt == FRAME_PIX - 19'd1)) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_FLUSH;
                end
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        w_emit = (r_op == OP_BYPASS) ? w_xfer : (w_en && (r_en_cnt >= LAT));
    end

    // Result pixel: dilation is erosion of the complement, so invert back on the way out.
    always_comb begin
        if (r_op == OP_BYPASS) begin
            w_pix = in_pixel;
        end else if (w_border) begin
            w_pix = 1'b0;
        end else if (r_op == OP_DILATE) begin
            w_pix = ~core_dout;
        end else begin
            w_pix = core_dout;
        end
    end

    // State register and op latch; op_sel is captured only on an accepted start.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_op    <= OP_BYPASS;
        end else begin
            r_state <= w_next;
            r_op    <= ((r_state == ST_IDLE) && start) ? decode_op(op_sel) : r_op;
        end
    end

    // Transfer, enable and output counters, zeroed in the CLEAR cycle.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_in_cnt  <= 19'd0;
            r_en_cnt  <= 19'd0;
            r_out_cnt <= 19'd0;
        end else if (r_state == ST_CLEAR) begin
            r_in_cnt  <= 19'd0;
            r_en_cnt  <= 19'd0;
            r_out_cnt <= 19'd0;
        end else begin
            r_in_cnt  <= r_in_cnt  + {18'd0, w_xfer};
            r_en_cnt  <= r_en_cnt  + {18'd0, w_en};
            r_out_cnt <= r_out_cnt + {18'd0, w_emit};
        end
    end

    // Registered result stream and status.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_out_valid <= 1'b0;
            r_out_pixel <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_out_valid <= w_emit;
            r_out_pixel <= w_emit & w_pix;
            r_out_sof   <= w_emit & w_sof;
            r_out_eol   <= w_emit & w_eol;
            r_busy      <= (w_next != ST_IDLE);
            r_done      <= (w_next == ST_DONE);
        end
    end

    morph_pos_counter #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT)
    ) u_pos (
        .i_clk    (CLK),
        .i_rst_n  (RST),
        .i_clr    (r_state == ST_CLEAR),
        .i_adv    (w_emit),
        .o_sof    (w_sof),
        .o_eol    (w_eol),
        .o_border (w_border)
    );

    // Core-side strobes are forced safe while reset is asserted.
    assign in_ready  = RST & w_ready;
    assign core_en   = RST & w_en;
    assign core_din  = RST & w_din;
    assign core_clr  = ~RST | w_clr;
    assign out_valid = r_out_valid;
    assign out_pixel = r_out_pixel;
    assign out_sof   = r_out_sof;
    assign out_eol   = r_out_eol;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: doc/morph_sequencer.md
MORPH_SEQUENCER -- requirements
Module: morph_sequencer

Interface
REQ-001 Parameter H_ACT, default 640, active pixels per line.
REQ-002 Parameter V_ACT, default 480, active lines per frame.
REQ-003 Parameter CORE_LAT, default 641, enables from a pixel entering core_din to its window centre on core_dout.
REQ-004 CLK  in  1  sole clock; one clock; reset is synchronous and active-low.
REQ-005 RST  in  1  synchronous active-low reset.
REQ-006 start  in  1  frame-start pulse; honoured only in IDLE.
REQ-007 op_sel  in  2  00 bypass, 01 erode, 10 dilate, 11 treated as bypass; latched on accepted start.
REQ-008 in_valid / in_pixel / in_ready  in / in / out  1 each  binary pixel stream, raster order, transfer when valid&ready.
REQ-009 core_clr  out  1  active-high clear to the 3x3 erosion core and its line buffers.
REQ-010 core_en  out  1  shift enable to the core.
REQ-011 core_din  out  1  pixel to the core.
REQ-012 core_dout  in  1  core result, sampled in cycles with core_en=1.
REQ-013 out_valid / out_pixel / out_sof / out_eol  out  1 each  registered result stream; no backpressure.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse at frame completion.

Function
REQ-016 FSM states: IDLE, CLEAR, RUN, FLUSH, DONE.
REQ-017 IDLE->CLEAR on start; CLEAR lasts exactly 1 cycle, with core_clr=1, core_en=0, and counters zeroed.
REQ-018 CLEAR->RUN unconditionally.
REQ-019 RUN: in_ready=1; core_en = in_valid; core_din = in_pixel for erode and ~in_pixel for dilate.
REQ-020 RUN->FLUSH after the H_ACT*V_ACT-th accepted pixel (erode/dilate); RUN->DONE instead in bypass.
REQ-021 FLUSH: in_ready=0, core_en=1 every cycle, core_din=0.
REQ-022 FLUSH->DONE when the output count reaches H_ACT*V_ACT.
REQ-023 DONE: done=1 for one cycle, then ->IDLE.
REQ-024 Enable counter en_cnt, 19 bits, counts core_en cycles.
REQ-025 A core_en cycle with en_cnt >= CORE_LAT produces one output on the next cycle; out_pixel = core_dout for erode, ~core_dout for dilate.
REQ-026 Bypass: out_pixel = in_pixel, registered 1 cycle after the transfer; the core is not enabled.
REQ-027 Output row counter (9 bits) and column counter (10 bits) track the output position; the column wraps at H_ACT-1 and increments the row.
REQ-028 Border: in erode/dilate, out_pixel is forced 0 at row 0, row V_ACT-1, column 0 and column H_ACT-1.
REQ-029 out_sof=1 with the output at (0,0); out_eol=1 with each output at column H_ACT-1.
REQ-030 start while busy is ignored; op_sel changes while busy have no effect.
REQ-031 in_valid low in RUN stalls core_en and the output stream with no data loss.
REQ-032 Outputs and in_ready outside RUN/FLUSH: out_valid=0, in_ready=0, core_en=0.

Reset
REQ-033 RST low at any clock edge, including mid-frame: next state IDLE, all counters 0, op_sel latch 00, core_clr=1 while RST is low.
REQ-034 Reset values: in_ready=0, core_en=0, core_din=0, out_valid=0, out_pixel=0, out_sof=0, out_eol=0, busy=0, done=0.

Structure
REQ-035 Shared package morph_pkg holds the FSM state enum, the op_sel enum, and the default constants H_ACT, V_ACT and CORE_LAT.
REQ-036 A single sub-module, morph_pos_counter (row/column counter with wrap, sof and eol flags), is instantiated once for the output position.

Verification
REQ-037 Erode, H_ACT=8, V_ACT=6, CORE_LAT=9, all-ones frame -> 48 outputs; interior 4x6 = 1, border = 0; sof at output 0; done exactly once.
REQ-038 Dilate on a single 1 at (3,3) of an 8x6 frame -> 3x3 block of ones at rows 2-4, columns 2-4; all else 0.
REQ-039 Bypass on a checkerboard -> output identical to input, 1-cycle latency, no FLUSH, core_en never high.
REQ-040 Random in_valid gaps at 30% -> output bitstream identical to the gap-free run; out_eol every 8 outputs.
REQ-041 RST low at transfer 20, released, new start -> first frame truncated with no done; second frame correct; core_clr seen.
REQ-042 start pulsed during RUN and op_sel toggled mid-frame -> no effect; exactly 48 outputs and one done.
